pkt_gen: RTL and testbench

PKT_GEN -- requirements
Module: pkt_gen

---
 rtl/pkt_gen_pkg.sv | 31 +++
 rtl/pkt_gen_prbs8.sv | 29 ++
 rtl/pkt_gen.sv | 162 ++++++++++++++++
 tb/tb_pkt_gen.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_gen_pkg.sv
// Shared types and constants for the packet generator.
//   mode_e       : data source selection for a run
//   state_e      : generator FSM states
//   PRBS_POLY    : tap mask for x^8 + x^6 + x^5 + x^4 + 1 (bits 7,5,4,3)
//   PRBS_SEED    : LFSR value at reset and at the start of every run
//   prbs8_next() : one Fibonacci shift of the LFSR
package pkt_gen_pkg;

  typedef enum logic [1:0] {
    MODE_MEM  = 2'd0,
    MODE_INC  = 2'd1,
    MODE_PRBS = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_IPG  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [7:0] PRBS_POLY = 8'hB8;
  localparam logic [7:0] PRBS_SEED = 8'hFF;

  // Shift left; the new bit 0 is the XOR of the tapped bits.
  function automatic logic [7:0] prbs8_next(input logic [7:0] s);
    return {s[6:0], ^(s & PRBS_POLY)};
  endfunction

endpackage

// File: rtl/pkt_gen_prbs8.sv
// PRBS8 generator used as the mode-2 data source.
//   clk_a : clock, rising edge
//   rst_n : synchronous active-low reset, loads PRBS_SEED
//   load  : reload PRBS_SEED (start of a run); wins over adv
//   adv   : advance one step (one accepted word)
//   lfsr  : current LFSR state
module pkt_gen_prbs8
  import pkt_gen_pkg::*;
(
  input  logic       clk_a,
  input  logic       rst_n,
  input  logic       load,
  input  logic       adv,
  output logic [7:0] lfsr
);

  // NOTE: clocked state is always written with <= so every register samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk_a) begin
    if (!rst_n) begin
      lfsr <= PRBS_SEED;
    end else if (load) begin
      lfsr <= PRBS_SEED;
    end else if (adv) begin
      lfsr <= prbs8_next(lfsr);
    end
  end

endmodule

// File: rtl/pkt_gen.sv
// Packet generator: emits num_pkts frames of frame_len words with ipg idle
// cycles between them over a valid/ready handshake.
//   clk_a, rst_n                : clock, synchronous active-low reset
//   start, stop                 : begin a run / request a graceful end
//   mode, frame_len, num_pkts, ipg : run configuration, latched on start
//   wr_en, wr_addr, wr_data     : pattern memory write port (idle only)
//   err_inject                  : arm a one-shot bit-0 flip on the next word
//   ready_a                     : downstream accept
//   data_valid_a, data_a, sof, eof : output word and framing flags
//   busy, done, pkt_count       : run status
module pkt_gen
  import pkt_gen_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BYTES = 64,
  parameter int CNT_W     = 16
) (
  input  logic                           clk_a,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           stop,
  input  logic [1:0]                     mode,
  input  logic [$clog2(MAX_BYTES+1)-1:0] frame_len,
  input  logic [CNT_W-1:0]               num_pkts,
  input  logic [CNT_W-1:0]               ipg,
  input  logic                           wr_en,
  input  logic [$clog2(MAX_BYTES)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           err_inject,
  input  logic                           ready_a,
  output logic                           data_valid_a,
  output logic [WIDTH-1:0]               data_a,
  output logic                           sof,
  output logic                           eof,
  output logic                           busy,
  output logic                           done,
  output logic [CNT_W-1:0]               pkt_count
);

  localparam int LEN_W = $clog2(MAX_BYTES + 1);
  localparam int AW    = $clog2(MAX_BYTES);

  state_e            state_q, state_d;
  mode_e             mode_q;
  logic [LEN_W-1:0]  len_q, idx_q, len_clamped;
  logic [CNT_W-1:0]  num_q, ipg_q, ipg_cnt;
  logic              stop_pend, err_armed, err_req;
  logic              send_st, accept, stall, last_word, last_pkt;
  logic [7:0]        lfsr;
  logic [WIDTH-1:0]  word;
  logic [WIDTH-1:0]  mem [MAX_BYTES];

  assign len_clamped = (frame_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : frame_len;
  assign send_st     = (state_q == S_SEND);
  assign accept      = send_st && ready_a;
  assign stall       = send_st && !ready_a;
  assign last_word   = (idx_q == len_q - LEN_W'(1));
  assign last_pkt    = ({1'b0, pkt_count} + (CNT_W+1)'(1)) == {1'b0, num_q};

  pkt_gen_prbs8 u_prbs (
    .clk_a (clk_a),
    .rst_n (rst_n),
    .load  (state_q == S_IDLE && start),
    .adv   (accept),
    .lfsr  (lfsr)
  );

  always_ff @(posedge clk_a) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = (len_clamped == '0 || num_pkts == '0) ? S_DONE : S_SEND;
      S_SEND: if (ready_a && last_word) begin
        // A stop arriving on the eof beat still ends the run after this packet.
        if (last_pkt || stop_pend || stop) state_d = S_DONE;
        else if (ipg_q == '0)              state_d = S_SEND;
        else                               state_d = S_IPG;
      end
      S_IPG:  if (stop) state_d = S_DONE;
              else if (ipg_cnt == '0) state_d = S_SEND;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    unique case (mode_q)
      MODE_INC:  word = WIDTH'(idx_q);
      MODE_PRBS: word = WIDTH'(lfsr);
      default:   word = mem[idx_q[AW-1:0]];
    endcase
  end

  always_comb begin
    data_valid_a = send_st;
    sof          = send_st && (idx_q == '0);
    eof          = send_st && last_word;
    data_a       = send_st ? (word ^ WIDTH'(err_armed)) : '0;
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_DONE);
  end

  always_ff @(posedge clk_a) begin
    if (!rst_n) begin
      mode_q    <= MODE_MEM;
      len_q     <= '0;
      num_q     <= '0;
      ipg_q     <= '0;
      ipg_cnt   <= '0;
      idx_q     <= '0;
      pkt_count <= '0;
      stop_pend <= 1'b0;
      err_armed <= 1'b0;
      err_req   <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start) begin
        mode_q    <= mode_e'(mode);
        len_q     <= len_clamped;
        num_q     <= num_pkts;
        ipg_q     <= ipg;
        idx_q     <= '0;
        pkt_count <= '0;
        stop_pend <= 1'b0;
      end
      if (send_st && stop)     stop_pend <= 1'b1;
      if (state_q == S_DONE)   stop_pend <= 1'b0;

      if (accept) begin
        idx_q <= last_word ? '0 : idx_q + LEN_W'(1);
        if (last_word && pkt_count != '1) pkt_count <= pkt_count + CNT_W'(1);
      end

      // Loaded with ipg-1 so the IPG state lasts exactly ipg cycles.
      if (send_st && state_d == S_IPG) ipg_cnt <= ipg_q - CNT_W'(1);
      else if (state_q == S_IPG)       ipg_cnt <= ipg_cnt - CNT_W'(1);

      // A pulse landing while a word is stalled is parked in err_req so the
      // presented word never changes before it is accepted.
      if (accept && err_armed) begin
        err_armed <= 1'b0;
      end else if ((err_inject || err_req) && !err_armed && !stall) begin
        err_armed <= 1'b1;
        err_req   <= 1'b0;
      end else if (err_inject && !err_armed && stall) begin
        err_req   <= 1'b1;
      end
    end
  end

  // NOTE: the pattern memory has no reset; its contents survive rst_n and
  // a reset-free array maps onto RAM resources.
  always_ff @(posedge clk_a) begin
    if (wr_en && state_q == S_IDLE) mem[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_pkt_gen.sv
module tb_pkt_gen;
  localparam int WIDTH     = 8;
  localparam int MAX_BYTES = 64;
  localparam int CNT_W     = 16;
  localparam int LEN_W     = $clog2(MAX_BYTES + 1);
  localparam int AW        = $clog2(MAX_BYTES);

  logic             clk_a = 1'b0;
  logic             rst_n, start, stop, wr_en, err_inject, ready_a;
  logic [1:0]       mode;
  logic [LEN_W-1:0] frame_len;
  logic [CNT_W-1:0] num_pkts, ipg, pkt_count;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data, data_a;
  logic             data_valid_a, sof, eof, busy, done;

  int total = 0;
  int bad   = 0;
  logic [7:0] pat [42];

  pkt_gen #(.WIDTH(WIDTH), .MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) dut (
    .clk_a(clk_a), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .frame_len(frame_len), .num_pkts(num_pkts), .ipg(ipg), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .err_inject(err_inject),
    .ready_a(ready_a), .data_valid_a(data_valid_a), .data_a(data_a),
    .sof(sof), .eof(eof), .busy(busy), .done(done), .pkt_count(pkt_count)
  );

  always #5 clk_a = ~clk_a;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled and inputs driven 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk_a);
    #1;
  endtask

  task automatic expect_word(input string tag, input int w, input logic [7:0] d,
                             input logic s, input logic e);
    check($sformatf("%s w%0d valid", tag, w), 32'(data_valid_a), 32'd1);
    check($sformatf("%s w%0d data", tag, w), 32'(data_a), 32'(d));
    check($sformatf("%s w%0d sof", tag, w), 32'(sof), 32'(s));
    check($sformatf("%s w%0d eof", tag, w), 32'(eof), 32'(e));
  endtask

  task automatic expect_idle_gap(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s gap%0d valid", tag, k), 32'(data_valid_a), 32'd0);
      check($sformatf("%s gap%0d busy", tag, k), 32'(busy), 32'd1);
      tick();
    end
  endtask

  task automatic expect_done(input string tag, input int cnt);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy in DONE"}, 32'(busy), 32'd1);
    check({tag, " valid in DONE"}, 32'(data_valid_a), 32'd0);
    check({tag, " pkt_count"}, 32'(pkt_count), 32'(cnt));
    tick();
    check({tag, " done cleared"}, 32'(done), 32'd0);
    check({tag, " busy cleared"}, 32'(busy), 32'd0);
  endtask

  task automatic start_run(input logic [1:0] m, input logic [LEN_W-1:0] len,
                           input logic [CNT_W-1:0] n, input logic [CNT_W-1:0] g);
    mode = m; frame_len = len; num_pkts = n; ipg = g;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] m;
    int e;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; wr_en = 1'b0; err_inject = 1'b0;
    ready_a = 1'b1; mode = 2'd0; frame_len = '0; num_pkts = '0; ipg = '0;
    wr_addr = '0; wr_data = '0;
    repeat (3) tick();
    check("rst valid", 32'(data_valid_a), 32'd0);
    check("rst data", 32'(data_a), 32'd0);
    check("rst sof", 32'(sof), 32'd0);
    check("rst eof", 32'(eof), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst pkt_count", 32'(pkt_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // Load a 42-word pattern while idle.
    for (int i = 0; i < 42; i++) begin
      pat[i] = 8'(i * 7 + 3);
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = pat[i];
      tick();
    end
    wr_en = 1'b0;

    // Scenario 1: three 42-word packets from memory, 10-cycle gaps.
    // A write to address 0 during the run must be dropped.
    start_run(2'd0, 42, 3, 10);
    for (int p = 0; p < 3; p++) begin
      for (int w = 0; w < 42; w++) begin
        expect_word($sformatf("s1 p%0d", p), w, pat[w], w == 0, w == 41);
        if (p == 0 && w == 5) begin
          wr_en = 1'b1; wr_addr = '0; wr_data = 8'hAA;
        end
        tick();
        wr_en = 1'b0;
      end
      if (p < 2) expect_idle_gap($sformatf("s1 p%0d", p), 10);
    end
    expect_done("s1", 3);

    // Reserved mode reads memory like mode 0.
    start_run(2'd3, 2, 1, 0);
    expect_word("s1r", 0, pat[0], 1'b1, 1'b0); tick();
    expect_word("s1r", 1, pat[1], 1'b0, 1'b1); tick();
    expect_done("s1r", 1);

    // Scenario 2: incrementing data with ready toggling every cycle.
    ready_a = 1'b0;
    start_run(2'd1, 4, 1, 0);
    e = 0;
    for (int c = 0; c < 16 && e < 4; c++) begin
      expect_word("s2", e, 8'(e), e == 0, e == 3);
      ready_a = c[0];
      tick();
      if (ready_a) e++;
    end
    check("s2 all words accepted", 32'(e), 32'd4);
    ready_a = 1'b1;
    expect_done("s2", 1);

    // Scenario 3: PRBS8 data against an independent bit-level model.
    m = 8'hFF;
    start_run(2'd2, 3, 1, 0);
    for (int w = 0; w < 3; w++) begin
      expect_word("s3", w, m, w == 0, w == 2);
      m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
      tick();
    end
    expect_done("s3", 1);

    // Scenario 4a: stop during packet 2 lets it finish, then DONE.
    // A start pulse inside the gap is ignored.
    start_run(2'd1, 4, 5, 3);
    for (int w = 0; w < 4; w++) begin
      expect_word("s4a p0", w, 8'(w), w == 0, w == 3); tick();
    end
    start = 1'b1;
    expect_idle_gap("s4a", 1);
    start = 1'b0;
    expect_idle_gap("s4a", 2);
    for (int w = 0; w < 4; w++) begin
      expect_word("s4a p1", w, 8'(w), w == 0, w == 3);
      stop = (w == 1);
      tick();
      stop = 1'b0;
    end
    expect_done("s4a", 2);

    // Scenario 4b: stop inside the gap ends the run on the next cycle.
    start_run(2'd1, 4, 5, 6);
    for (int w = 0; w < 4; w++) begin
      expect_word("s4b", w, 8'(w), w == 0, w == 3); tick();
    end
    expect_idle_gap("s4b", 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    expect_done("s4b", 1);

    // Scenario 5: error armed while word 4 is on the bus flips word 5.
    start_run(2'd1, 8, 1, 0);
    for (int w = 0; w < 8; w++) begin
      expect_word("s5", w, (w == 5) ? 8'h04 : 8'(w), w == 0, w == 7);
      err_inject = (w == 4);
      tick();
      err_inject = 1'b0;
    end
    expect_done("s5", 1);

    // Armed while idle (twice) persists into the next run, flips one word only.
    err_inject = 1'b1; tick(); tick(); err_inject = 1'b0;
    start_run(2'd1, 2, 1, 0);
    expect_word("s5b", 0, 8'h01, 1'b1, 1'b0); tick();
    expect_word("s5b", 1, 8'h01, 1'b0, 1'b1); tick();
    expect_done("s5b", 1);

    // Simultaneous start and stop: run starts; ipg 0 gives back-to-back packets.
    stop = 1'b1;
    start_run(2'd1, 2, 2, 0);
    stop = 1'b0;
    for (int w = 0; w < 4; w++) begin
      expect_word("s5c", w, 8'(w % 2), (w % 2) == 0, (w % 2) == 1); tick();
    end
    expect_done("s5c", 2);

    // Scenario 6: reset at word 10 aborts without done; memory survives.
    start_run(2'd0, 42, 1, 0);
    for (int w = 0; w <= 10; w++) begin
      expect_word("s6a", w, pat[w], w == 0, 1'b0);
      if (w == 10) rst_n = 1'b0;
      tick();
    end
    check("s6 rst valid", 32'(data_valid_a), 32'd0);
    check("s6 rst done", 32'(done), 32'd0);
    check("s6 rst busy", 32'(busy), 32'd0);
    check("s6 rst data", 32'(data_a), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("s6 no done %0d", k), 32'(done), 32'd0);
    end
    start_run(2'd0, 42, 1, 0);
    for (int w = 0; w < 42; w++) begin
      expect_word("s6b", w, pat[w], w == 0, w == 41); tick();
    end
    expect_done("s6b", 1);

    // frame_len 0 and num_pkts 0 both go straight to DONE with no data.
    start_run(2'd1, 0, 3, 0);
    expect_done("s6 len0", 0);
    start_run(2'd1, 4, 0, 0);
    expect_done("s6 num0", 0);

    // frame_len above MAX_BYTES is clamped to 64 words.
    start_run(2'd1, 100, 1, 0);
    for (int w = 0; w < 64; w++) begin
      expect_word("clamp", w, 8'(w), w == 0, w == 63); tick();
    end
    expect_done("clamp", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
